pkt_tx_sched: RTL

Credit-based weighted round-robin scheduler for the SerDes TX traffic manager. It arbitrates up to CHAN_NUMS packet-ready requesters. Each channel holds a signed credit balance: periodic refill adds a per-channel quantum, and each completed packet debits its length. One grant is issued at a time through a grant/ack/done handshake. It sits between the per-channel input buffers and the TX read state machine, and sets the share of link bandwidth each channel receives.

---
 rtl/pkt_sched_pkg.sv | 27 ++
 rtl/pkt_tx_sched_rr_pick.sv | 26 ++
 rtl/pkt_tx_sched.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pkt_sched_pkg.sv
// rtl/pkt_sched_pkg.sv - state encoding, width defaults and credit arithmetic for pkt_tx_sched
package pkt_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_GRANT = 3'b010,
    ST_BUSY  = 3'b100
  } sched_state_t;

  localparam int CREDIT_W_DEF = 14;
  localparam int LEN_W_DEF    = 10;

  // 32-bit working width so credit + quantum - len can never wrap before clamping
  function automatic logic signed [31:0] sat_add(
    input logic signed [31:0] base,
    input logic signed [31:0] delta,
    input logic signed [31:0] lo,
    input logic signed [31:0] hi
  );
    logic signed [31:0] sum;
    sum = base + delta;
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/pkt_tx_sched_rr_pick.sv
// rtl/pkt_tx_sched_rr_pick.sv - rotating-priority picker: first set mask bit at or after ptr+1, cyclic
module rr_pick #(
  parameter int N  = 8,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_mask,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_winner,
  output logic          o_found
);

  always_comb begin : pick
    logic [PW-1:0] idx;
    o_winner = '0;
    o_found  = 1'b0;
    idx      = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(i_ptr) + k) % N);
      if (!o_found && i_mask[idx]) begin
        o_winner[idx] = 1'b1;
        o_found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pkt_tx_sched.sv
// rtl/pkt_tx_sched.sv - credit-based weighted round-robin TX scheduler with grant/ack/done handshake
// Optional PKT_SCHED_WORK_CONSERVE_EN: grant requesters regardless of credit when none is eligible.
module pkt_tx_sched
  import pkt_sched_pkg::*;
#(
  parameter int CHAN_NUMS     = 8,
  parameter int LEN_W         = LEN_W_DEF,
  parameter int CREDIT_W      = CREDIT_W_DEF,
  parameter int CREDIT_CAP    = 4095,
  parameter int REFILL_PERIOD = 256,
  parameter int QUANTUM_RST   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CHAN_NUMS-1:0] req,
  output logic                 grant_vld,
  output logic [CHAN_NUMS-1:0] grant,
  input  logic                 ack,
  input  logic                 done,
  input  logic [LEN_W-1:0]     done_len,
  input  logic                 cfg_wr,
  input  logic [3:0]           cfg_chan,
  input  logic [LEN_W-1:0]     cfg_quantum,
  output logic                 busy
);

  localparam int PW = $clog2(CHAN_NUMS);
  localparam int RW = $clog2(REFILL_PERIOD);
  localparam logic signed [31:0] CREDIT_MIN = -(32'sd1 <<< (CREDIT_W - 1));

  sched_state_t r_state, w_state_nxt;
  logic [CHAN_NUMS-1:0] r_grant, w_grant_nxt;
  logic [PW-1:0]        r_ptr, w_ptr_nxt, w_win_idx;
  logic signed [CREDIT_W-1:0] r_credit [CHAN_NUMS];
  logic [LEN_W-1:0]     r_quantum [CHAN_NUMS];
  logic [RW-1:0]        r_refill_cnt;
  logic signed [31:0]   w_delta [CHAN_NUMS];

  logic                 w_refill, w_debit;
  logic [CHAN_NUMS-1:0] w_elig, w_elig_win, w_win;
  logic                 w_elig_found, w_found;

  always_comb begin
    for (int i = 0; i < CHAN_NUMS; i++) begin
      w_elig[i] = req[i] & ~r_credit[i][CREDIT_W-1];
    end
  end

  rr_pick #(.N(CHAN_NUMS), .PW(PW)) u_pick_elig (
    .i_mask   (w_elig),
    .i_ptr    (r_ptr),
    .o_winner (w_elig_win),
    .o_found  (w_elig_found)
  );

`ifdef PKT_SCHED_WORK_CONSERVE_EN
  logic [CHAN_NUMS-1:0] w_req_win;
  logic                 w_req_found;

  rr_pick #(.N(CHAN_NUMS), .PW(PW)) u_pick_req (
    .i_mask   (req),
    .i_ptr    (r_ptr),
    .o_winner (w_req_win),
    .o_found  (w_req_found)
  );

  assign w_win   = w_elig_found ? w_elig_win : w_req_win;
  assign w_found = w_elig_found | w_req_found;
`else
  assign w_win   = w_elig_win;
  assign w_found = w_elig_found;
`endif

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < CHAN_NUMS; i++) begin
      if (w_win[i]) w_win_idx = PW'(i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_debit     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_grant_nxt = w_win;
          w_ptr_nxt   = w_win_idx;
        end
      end
      ST_GRANT: begin
        if (ack) w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (done) begin
          w_debit     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_ptr   <= PW'(CHAN_NUMS - 1);
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign w_refill = (r_refill_cnt == RW'(REFILL_PERIOD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_refill_cnt <= '0;
    else if (w_refill) r_refill_cnt <= '0;
    else               r_refill_cnt <= r_refill_cnt + 1'b1;
  end

  // r_grant stays valid through BUSY so it still selects the channel to debit
  always_comb begin
    for (int i = 0; i < CHAN_NUMS; i++) begin
      w_delta[i] = '0;
      if (w_refill) w_delta[i] = 32'(r_quantum[i]);
      if (w_debit && r_grant[i]) w_delta[i] = w_delta[i] - 32'(done_len);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHAN_NUMS; i++) begin
        r_credit[i]  <= '0;
        r_quantum[i] <= LEN_W'(QUANTUM_RST);
      end
    end else begin
      for (int i = 0; i < CHAN_NUMS; i++) begin
        if (w_refill || (w_debit && r_grant[i])) begin
          r_credit[i] <= CREDIT_W'(sat_add({{(32-CREDIT_W){r_credit[i][CREDIT_W-1]}}, r_credit[i]},
                                           w_delta[i], CREDIT_MIN, CREDIT_CAP));
        end
        if (cfg_wr && (cfg_chan == 4'(i))) r_quantum[i] <= cfg_quantum;
      end
    end
  end

  assign grant_vld = (r_state == ST_GRANT);
  assign grant     = grant_vld ? r_grant : '0;
  assign busy      = (r_state != ST_IDLE);

endmodule
